simon_data_in: RTL and testbench

//  Inbound packet unpacker for the SIMON core: the receive-side counterpart of the byte-packet output stage.

---
 rtl/simon_data_in_pkg.sv | 29 ++
 rtl/simon_data_in_if.sv | 34 +++
 rtl/simon_pkt_unpack.sv | 19 +
 rtl/simon_data_in.sv | 106 ++++++++++
 tb/tb_simon_data_in.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/simon_data_in_pkg.sv
// Shared SIMON definitions: word width, info codes, FSM states
// and packet sizing helpers for the inbound packet path.
package simon_data_in_pkg;

    localparam int SIMON_N = 16;

    localparam logic [7:0] INFO_ENC = 8'h01;
    localparam logic [7:0] INFO_DEC = 8'h02;
    localparam logic [7:0] INFO_KEY = 8'h03;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        PRESENT,
        REL
    } state_t;

    function automatic int pkt_bytes(input int n);
        return 2 + n / 2;
    endfunction

    localparam int PKT_BYTES = pkt_bytes(SIMON_N);

    function automatic logic info_valid(input logic [7:0] code);
        return (code == INFO_ENC) || (code == INFO_DEC) ||
               (code == INFO_KEY);
    endfunction

endpackage

// File: rtl/simon_data_in_if.sv
// Host-link and core-side handshake bundle of the packet unpacker.
// master = host/core environment, slave = simon_data_in.
interface simon_data_in_if
    import simon_data_in_pkg::*;
#(
    parameter int N = SIMON_N
);
    localparam int PB = pkt_bytes(N);

    logic [PB-1:0][7:0] in;
    logic               in_donePKT;
    logic               in_readPKT;
    logic [7:0]         infoIN;
    logic [7:0]         countIN;
    logic [1:0][N-1:0]  inDATA;
    logic [1:0][N-1:0]  inKEY;
    logic               doneDATA;
    logic               readDATA;
    logic               seq_err;
    logic               info_err;

    modport master (
        output in, in_donePKT, readDATA,
        input  in_readPKT, infoIN, countIN, inDATA, inKEY,
        input  doneDATA, seq_err, info_err
    );

    modport slave (
        input  in, in_donePKT, readDATA,
        output in_readPKT, infoIN, countIN, inDATA, inKEY,
        output doneDATA, seq_err, info_err
    );

endinterface

// File: rtl/simon_pkt_unpack.sv
// Combinational split of the N/2 payload bytes into two block words
// and two key words; lowest-index byte is the least-significant byte.
module simon_pkt_unpack #(
    parameter int N = 16
) (
    input  logic [N/2-1:0][7:0] i_payload,
    output logic [1:0][N-1:0]   o_data,
    output logic [1:0][N-1:0]   o_key
);

    logic [4*N-1:0] w_flat;

    assign w_flat    = i_payload;
    assign o_data[0] = w_flat[0*N +: N];
    assign o_data[1] = w_flat[1*N +: N];
    assign o_key[0]  = w_flat[2*N +: N];
    assign o_key[1]  = w_flat[3*N +: N];

endmodule

// File: rtl/simon_data_in.sv
// Inbound SIMON packet unpacker: 4-phase capture from the host,
// header checks, 4-phase presentation of block/key words to the core.
module simon_data_in
    import simon_data_in_pkg::*;
#(
    parameter int N = SIMON_N
) (
    input logic          clk,
    input logic          nR,
    simon_data_in_if.slave bus
);

    localparam int PB = pkt_bytes(N);

    if ((N % 8) != 0) begin : g_bad_n
        $error("simon_data_in: N must be a multiple of 8");
    end

    state_t             r_state;
    state_t             w_next;
    logic               r_ack;
    logic               r_done;
    logic               r_info_ok;
    logic [7:0]         r_info;
    logic [7:0]         r_count;
    logic [7:0]         r_exp;
    logic [1:0][N-1:0]  r_data;
    logic [1:0][N-1:0]  r_key;
    logic               r_seq_err;
    logic               r_info_err;

    logic [PB-3:0][7:0] w_payload;
    logic [1:0][N-1:0]  w_data;
    logic [1:0][N-1:0]  w_key;
    logic               w_capture;

    assign w_payload = bus.in[PB-1:2];
    assign w_capture = (r_state == IDLE) && bus.in_donePKT;

    simon_pkt_unpack #(.N(N)) u_unpack (
        .i_payload (w_payload),
        .o_data    (w_data),
        .o_key     (w_key)
    );

    // Next-state logic for the two back-to-back 4-phase handshakes.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_donePKT) w_next = ACK;
            ACK:     if (!bus.in_donePKT)
                         w_next = r_info_ok ? PRESENT : IDLE;
            PRESENT: if (bus.readDATA) w_next = REL;
            REL:     if (!bus.readDATA) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == ACK);
            r_done  <= (w_next == PRESENT);
        end
    end

    // Packet capture, count resync and sticky header error flags.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_info     <= '0;
            r_count    <= '0;
            r_exp      <= '0;
            r_data     <= '0;
            r_key      <= '0;
            r_info_ok  <= 1'b0;
            r_seq_err  <= 1'b0;
            r_info_err <= 1'b0;
        end else if (w_capture) begin
            r_info    <= bus.in[0];
            r_count   <= bus.in[1];
            r_exp     <= bus.in[1] + 8'd1;
            r_data    <= w_data;
            r_key     <= w_key;
            r_info_ok <= info_valid(bus.in[0]);
            if (bus.in[1] != r_exp)
                r_seq_err <= 1'b1;
            if (!info_valid(bus.in[0]))
                r_info_err <= 1'b1;
        end
    end

    assign bus.in_readPKT = r_ack;
    assign bus.doneDATA   = r_done;
    assign bus.infoIN     = r_info;
    assign bus.countIN    = r_count;
    assign bus.inDATA     = r_data;
    assign bus.inKEY      = r_key;
    assign bus.seq_err    = r_seq_err;
    assign bus.info_err   = r_info_err;

endmodule

// File: tb/tb_simon_data_in.sv
// Self-checking bench for simon_data_in (N=16): vector table,
// scoreboard of presented words, reset and count-wrap sequences.
module tb_simon_data_in;
    import simon_data_in_pkg::*;

    localparam int N  = 16;
    localparam int PB = 10;

    logic clk = 1'b0;
    logic nR  = 1'b0;

    always #5 clk = ~clk;

    simon_data_in_if #(.N(N)) bus();

    simon_data_in #(.N(N)) dut (
        .clk (clk),
        .nR  (nR),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] info;
        logic [7:0] count;
        logic [7:0] base;
        bit         present;
        bit         seq_e;
        bit         info_e;
        int         stall;
    } vec_t;

    typedef struct {
        logic [7:0]   info;
        logic [7:0]   count;
        logic [N-1:0] d0;
        logic [N-1:0] d1;
        logic [N-1:0] k0;
        logic [N-1:0] k1;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pkt(input vec_t v);
        bus.in[0] = v.info;
        bus.in[1] = v.count;
        for (int i = 0; i < 8; i++)
            bus.in[2+i] = v.base + 8'(i);
    endtask

    function automatic exp_t model(input vec_t v);
        exp_t       e;
        logic [7:0] b [8];
        for (int i = 0; i < 8; i++)
            b[i] = v.base + 8'(i);
        e.info  = v.info;
        e.count = v.count;
        e.d0    = {b[1], b[0]};
        e.d1    = {b[3], b[2]};
        e.k0    = {b[5], b[4]};
        e.k1    = {b[7], b[6]};
        return e;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int   k;
        exp_t e;
        drive_pkt(v);
        bus.in_donePKT = 1'b1;
        k = 0;
        while (!bus.in_readPKT && k < 10) begin
            tick();
            k++;
        end
        chk({tag, " ack"}, bus.in_readPKT, 1);
        chk({tag, " info"}, bus.infoIN, v.info);
        chk({tag, " count"}, bus.countIN, v.count);
        chk({tag, " seq_err"}, bus.seq_err, v.seq_e);
        chk({tag, " info_err"}, bus.info_err, v.info_e);
        chk({tag, " done_in_ack"}, bus.doneDATA, 0);
        bus.in[0] = 8'h55;
        tick();
        chk({tag, " ack_held"}, bus.in_readPKT, 1);
        chk({tag, " in_ignored"}, bus.infoIN, v.info);
        drive_pkt(v);
        bus.in_donePKT = 1'b0;
        if (v.present) begin
            sb.push_back(model(v));
            tick();
            chk({tag, " done_latency"}, bus.doneDATA, 1);
            chk({tag, " ack_drop"}, bus.in_readPKT, 0);
            k = 0;
            while (!bus.doneDATA && k < 10) begin
                tick();
                k++;
            end
            e = sb.pop_front();
            chk({tag, " sb_info"}, bus.infoIN, e.info);
            chk({tag, " sb_count"}, bus.countIN, e.count);
            chk({tag, " sb_d0"}, bus.inDATA[0], e.d0);
            chk({tag, " sb_d1"}, bus.inDATA[1], e.d1);
            chk({tag, " sb_k0"}, bus.inKEY[0], e.k0);
            chk({tag, " sb_k1"}, bus.inKEY[1], e.k1);
            for (int s = 0; s < v.stall; s++) begin
                tick();
                chk({tag, " stall_done"}, bus.doneDATA, 1);
                chk({tag, " stall_key1"}, bus.inKEY[1], e.k1);
            end
            bus.readDATA = 1'b1;
            tick();
            chk({tag, " done_fall"}, bus.doneDATA, 0);
            chk({tag, " rel_data"}, bus.inDATA[0], e.d0);
            bus.readDATA = 1'b0;
            tick();
            chk({tag, " idle_done"}, bus.doneDATA, 0);
        end else begin
            for (int s = 0; s < 5; s++) begin
                tick();
                chk({tag, " no_present"}, bus.doneDATA, 0);
                chk({tag, " ack_gone"}, bus.in_readPKT, 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        vec_t v;
        int   k;

        tbl[0] = '{8'h02, 8'h00, 8'h80, 1, 0, 0, 20};
        tbl[1] = '{8'h01, 8'h01, 8'h11, 1, 0, 0, 0};
        tbl[2] = '{8'h03, 8'h03, 8'hA0, 1, 1, 0, 2};
        tbl[3] = '{8'h01, 8'h04, 8'hC0, 1, 1, 0, 0};
        tbl[4] = '{8'h7F, 8'h05, 8'hD0, 0, 1, 1, 0};
        tbl[5] = '{8'h02, 8'h06, 8'hE0, 1, 1, 1, 1};

        bus.in         = '0;
        bus.in_donePKT = 1'b0;
        bus.readDATA   = 1'b0;

        drive_pkt(tbl[0]);
        bus.in_donePKT = 1'b1;
        repeat (3) tick();
        chk("rst ack", bus.in_readPKT, 0);
        chk("rst done", bus.doneDATA, 0);
        chk("rst info", bus.infoIN, 0);
        chk("rst count", bus.countIN, 0);
        chk("rst data", bus.inDATA, 0);
        chk("rst key", bus.inKEY, 0);
        chk("rst seq_err", bus.seq_err, 0);
        chk("rst info_err", bus.info_err, 0);
        nR = 1'b1;
        tick();
        chk("rst release capture", bus.in_readPKT, 1);

        for (int i = 0; i < 6; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        v = '{8'h01, 8'h07, 8'h30, 1, 1, 1, 0};
        drive_pkt(v);
        bus.in_donePKT = 1'b1;
        k = 0;
        while (!bus.in_readPKT && k < 10) begin
            tick();
            k++;
        end
        chk("pr ack", bus.in_readPKT, 1);
        bus.in_donePKT = 1'b0;
        k = 0;
        while (!bus.doneDATA && k < 10) begin
            tick();
            k++;
        end
        chk("pr present", bus.doneDATA, 1);
        #2;
        nR = 1'b0;
        #1;
        chk("pr async done", bus.doneDATA, 0);
        chk("pr async data", bus.inDATA, 0);
        chk("pr async seq_err", bus.seq_err, 0);
        chk("pr async info_err", bus.info_err, 0);
        tick();
        nR = 1'b1;
        tick();

        for (int i = 0; i < 258; i++) begin
            v = '{8'h01, 8'(i), 8'(i * 3), 1, 0, 0, 0};
            run_vec(v, $sformatf("wrap%0d", i));
        end

        chk("sb empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
